led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
Multi-channel, parametrised successor to the single-LED rate blinker. Each of NUM_CH channels independently selects one of four half-period rates and one of four modes: OFF, solid ON, BLINK, or BURST (N pulses, then a gap). It sits between the board-control/switch logic and the LED pins, and drives status and heartbeat indicators from one system clock.

Parameters:
NUM_CH, 4, number of independent LED channels (1..16)
CNT_W, 16, per-channel half-period counter width
P_HALF_0, 125, half-period in clocks for rate_sel=00 (1 ≤ value ≤ 2^CNT_W)
P_HALF_1, 250, half-period for rate_sel=01
P_HALF_2, 1250, half-period for rate_sel=10
P_HALF_3, 12500, half-period for rate_sel=11
BURST_LEN, 3, on-pulses per burst (1..15)
GAP_HALVES, 4, burst gap length in half-periods (1..15)

Ports:
i_clock  in  1  system clock; all logic on rising edge
i_reset  in  1  synchronous reset, active-high
i_enable  in  1  global output enable; gates o_led_drive only
i_rate_sel  in  2*NUM_CH  per-channel rate select; channel c uses bits [2c+1:2c]
i_mode  in  2*NUM_CH  per-channel mode: 00 OFF, 01 ON, 10 BLINK, 11 BURST
o_led_drive  out  NUM_CH  LED drive, bit c = channel c
o_burst_done  out  NUM_CH  one-cycle pulse when channel c completes its last burst pulse

Behaviour:
- Clock and reset: one clock, i_clock. Reset i_reset is synchronous, active-high.
- Reset (any cycle, including mid-burst): on the next edge, all counters go to 0, phase goes to off, burst FSM goes to B_ON with pulse count 0, and prev_mode/prev_rate registers are cleared to 00. o_led_drive=0 and o_burst_done=0 after that edge.
- Per channel, half-period H = P_HALF_[rate_sel]. cnt counts 0..H-1. At cnt==H-1, cnt goes to 0 and a "half-tick" fires. H=1 gives a half-tick every cycle.
- Restart event: i_mode differs from prev_mode. Effect: cnt←0, phase←on, burst FSM←B_ON, pulse count←0. Because prev_mode resets to 00, any non-OFF mode at the first edge after reset is a restart.
- Rate-change event: i_rate_sel differs from prev_rate with no mode change. Effect: cnt←0 only; phase and burst state are preserved, so the current half-period is stretched. If a rate change and a mode change occur on the same edge, the restart takes effect.
- OFF: led_q=0; counter held at 0.
- ON: led_q=1.
- BLINK: phase toggles on each half-tick; led_q=phase. Output is on for H cycles, then off for H cycles; period 2H. The first active edge after a restart gives led_q=1.
- BURST FSM: B_ON → (half-tick) → B_OFF.
  - From B_OFF on a half-tick: if pulse count == BURST_LEN-1, go to B_GAP and pulse o_burst_done for one cycle on that edge; otherwise increment the count and go to B_ON.
  - B_GAP lasts GAP_HALVES half-ticks, then count←0 and → B_ON.
  - led_q=1 only in B_ON.
- led_q and o_burst_done are registered. o_led_drive = led_q & i_enable (combinational gate, zero latency). i_enable does not stall counters or FSMs, and does not gate o_burst_done.
- Mode or rate inputs changing every cycle cause a restart every cycle. This is legal; the channel stays at its first on-cycle.

Optional Feature:
LED_DIM_EN.
- Defined: adds input i_dim_level [3:0] (shared by all channels) and a free-running 4-bit pwm_cnt (reset 0, wraps 15→0). Wherever led_q=1, the output becomes led_q & (pwm_cnt < i_dim_level | i_dim_level==4'hF). Level 0 gives a dark output; level 15 gives full on. The enable gate is still applied last.
- Undefined: the port and counter do not exist, and the output is exactly as specified above.

Test Plan:
- Params P_HALF_0..3 = 2,3,4,5. Reset 2 cycles, then ch0 mode=10, rate=00 → o_led_drive[0] = 1,1,0,0,1,1… starting the first edge after reset deasserts.
- ch1 mode=11, rate=01, BURST_LEN=2, GAP_HALVES=2 → pattern 111000111000, then 000000 gap. o_burst_done[1] fires one cycle at the start of the gap. Pattern repeats with a period of 18 cycles.
- ch0 in BLINK at rate 11, 2 cycles into the on-phase, switch rate→00 → on-phase lasts 2+2=4 cycles total, then alternates with H=2.
- Assert i_reset mid-gap of a BURST channel → next edge: all outputs 0, burst_done 0. Release reset → that channel restarts from B_ON with output 1.
- i_enable=0 for 7 cycles during BLINK → o_led_drive=0 throughout. When it is reasserted, the output matches the ungated phase sequence (no phase slip).
- With LED_DIM_EN: ch2 mode=01, i_dim_level=4 → output high for 4 of every 16 cycles. Level 0 → always 0. Level 15 → always 1.

Source files
------------

// File: rtl/led_pattern_gen_if.sv
// ============================================================================
// Module   : led_pattern_gen_if
// Purpose  : Control/status bundle between the board logic and led_pattern_gen.
//            Carries i_dim_level only when LED_DIM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_pattern_gen_if #(
  parameter int NUM_CH = 4
);
  logic                  i_enable;
  logic [2*NUM_CH-1:0]   i_rate_sel;
  logic [2*NUM_CH-1:0]   i_mode;
`ifdef LED_DIM_EN
  logic [3:0]            i_dim_level;
`endif
  logic [NUM_CH-1:0]     o_led_drive;
  logic [NUM_CH-1:0]     o_burst_done;

`ifdef LED_DIM_EN
  modport master (
    output i_enable, i_rate_sel, i_mode, i_dim_level,
    input  o_led_drive, o_burst_done
  );
  modport slave (
    input  i_enable, i_rate_sel, i_mode, i_dim_level,
    output o_led_drive, o_burst_done
  );
`else
  modport master (
    output i_enable, i_rate_sel, i_mode,
    input  o_led_drive, o_burst_done
  );
  modport slave (
    input  i_enable, i_rate_sel, i_mode,
    output o_led_drive, o_burst_done
  );
`endif
endinterface

`default_nettype wire

// File: rtl/led_pattern_gen.sv
// ============================================================================
// Module   : led_pattern_gen
// Purpose  : NUM_CH independent LED channels, each OFF / ON / BLINK / BURST at
//            one of four half-period rates. Optional macro LED_DIM_EN adds a
//            shared 4-bit PWM dimmer (i_dim_level).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_gen #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int P_HALF_0   = 125,
  parameter int P_HALF_1   = 250,
  parameter int P_HALF_2   = 1250,
  parameter int P_HALF_3   = 12500,
  parameter int BURST_LEN  = 3,
  parameter int GAP_HALVES = 4
) (
  input  wire logic        i_clock,
  input  wire logic        i_reset,
  led_pattern_gen_if.slave bus
);

  localparam logic [1:0] C_MODE_OFF   = 2'b00;
  localparam logic [1:0] C_MODE_ON    = 2'b01;
  localparam logic [1:0] C_MODE_BLINK = 2'b10;
  localparam logic [1:0] C_MODE_BURST = 2'b11;

  // Counters hold H-1, so H = 2^CNT_W still fits in CNT_W bits.
  localparam logic [CNT_W-1:0] C_HM1_0 = CNT_W'(P_HALF_0 - 1);
  localparam logic [CNT_W-1:0] C_HM1_1 = CNT_W'(P_HALF_1 - 1);
  localparam logic [CNT_W-1:0] C_HM1_2 = CNT_W'(P_HALF_2 - 1);
  localparam logic [CNT_W-1:0] C_HM1_3 = CNT_W'(P_HALF_3 - 1);

  localparam logic [3:0] C_PCNT_LAST = 4'(BURST_LEN - 1);
  localparam logic [3:0] C_GCNT_LAST = 4'(GAP_HALVES - 1);

  typedef enum logic [1:0] {
    B_ON  = 2'd0,
    B_OFF = 2'd1,
    B_GAP = 2'd2
  } burst_state_t;

  logic [NUM_CH-1:0] w_led_q;
  logic [NUM_CH-1:0] w_done;
  logic [NUM_CH-1:0] w_led_lvl;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [1:0]       w_mode;
    logic [1:0]       w_rate;
    logic [CNT_W-1:0] w_hm1;
    logic             w_restart;
    logic             w_rate_chg;
    logic             w_tick;

    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic             r_phase,     w_phase_nxt;
    burst_state_t     r_bst,       w_bst_nxt;
    logic [3:0]       r_pcnt,      w_pcnt_nxt;
    logic [3:0]       r_gcnt,      w_gcnt_nxt;
    logic             r_led_q,     w_led_nxt;
    logic             r_done,      w_done_nxt;
    logic [1:0]       r_prev_mode;
    logic [1:0]       r_prev_rate;

    assign w_mode = bus.i_mode[2*c +: 2];
    assign w_rate = bus.i_rate_sel[2*c +: 2];

    always_comb begin
      w_hm1 = C_HM1_0;
      case (w_rate)
        2'b01:   w_hm1 = C_HM1_1;
        2'b10:   w_hm1 = C_HM1_2;
        2'b11:   w_hm1 = C_HM1_3;
        default: w_hm1 = C_HM1_0;
      endcase
    end

    // A mode change outranks a simultaneous rate change.
    assign w_restart  = (w_mode != r_prev_mode);
    assign w_rate_chg = !w_restart && (w_rate != r_prev_rate);
    assign w_tick     = !w_restart && !w_rate_chg &&
                        (w_mode != C_MODE_OFF) && (r_cnt == w_hm1);

    always_comb begin
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_phase_nxt = r_phase;
      w_bst_nxt   = r_bst;
      w_pcnt_nxt  = r_pcnt;
      w_gcnt_nxt  = r_gcnt;
      w_done_nxt  = 1'b0;
      w_led_nxt   = 1'b0;

      if (w_restart || w_rate_chg || w_tick || (w_mode == C_MODE_OFF))
        w_cnt_nxt = '0;

      if (w_restart) begin
        w_phase_nxt = 1'b1;
        w_bst_nxt   = B_ON;
        w_pcnt_nxt  = '0;
        w_gcnt_nxt  = '0;
      end else if (w_tick) begin
        w_phase_nxt = ~r_phase;
        if (w_mode == C_MODE_BURST) begin
          case (r_bst)
            B_ON: w_bst_nxt = B_OFF;
            B_OFF: begin
              if (r_pcnt == C_PCNT_LAST) begin
                w_bst_nxt  = B_GAP;
                w_gcnt_nxt = '0;
                w_done_nxt = 1'b1;
              end else begin
                w_pcnt_nxt = r_pcnt + 4'd1;
                w_bst_nxt  = B_ON;
              end
            end
            B_GAP: begin
              if (r_gcnt == C_GCNT_LAST) begin
                w_bst_nxt  = B_ON;
                w_pcnt_nxt = '0;
                w_gcnt_nxt = '0;
              end else begin
                w_gcnt_nxt = r_gcnt + 4'd1;
              end
            end
            default: w_bst_nxt = B_ON;
          endcase
        end
      end

      case (w_mode)
        C_MODE_ON:    w_led_nxt = 1'b1;
        C_MODE_BLINK: w_led_nxt = w_phase_nxt;
        C_MODE_BURST: w_led_nxt = (w_bst_nxt == B_ON);
        default:      w_led_nxt = 1'b0;
      endcase
    end

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        r_cnt       <= '0;
        r_phase     <= 1'b0;
        r_bst       <= B_ON;
        r_pcnt      <= '0;
        r_gcnt      <= '0;
        r_led_q     <= 1'b0;
        r_done      <= 1'b0;
        r_prev_mode <= 2'b00;
        r_prev_rate <= 2'b00;
      end else begin
        r_cnt       <= w_cnt_nxt;
        r_phase     <= w_phase_nxt;
        r_bst       <= w_bst_nxt;
        r_pcnt      <= w_pcnt_nxt;
        r_gcnt      <= w_gcnt_nxt;
        r_led_q     <= w_led_nxt;
        r_done      <= w_done_nxt;
        r_prev_mode <= w_mode;
        r_prev_rate <= w_rate;
      end
    end

    assign w_led_q[c] = r_led_q;
    assign w_done[c]  = r_done;
  end

`ifdef LED_DIM_EN
  logic [3:0] r_pwm_cnt;
  logic       w_dim_ok;

  always_ff @(posedge i_clock) begin
    if (i_reset)
      r_pwm_cnt <= 4'd0;
    else
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
  end

  // Level 15 bypasses the compare so it reaches a true 100% duty.
  assign w_dim_ok  = (r_pwm_cnt < bus.i_dim_level) || (bus.i_dim_level == 4'hF);
  assign w_led_lvl = w_led_q & {NUM_CH{w_dim_ok}};
`else
  assign w_led_lvl = w_led_q;
`endif

  assign bus.o_led_drive  = w_led_lvl & {NUM_CH{bus.i_enable}};
  assign bus.o_burst_done = w_done;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
// ============================================================================
// Module   : tb_led_pattern_gen
// Purpose  : Directed self-checking bench for led_pattern_gen (P_HALF 2,3,4,5,
//            BURST_LEN 2, GAP_HALVES 2). Dimmer test runs under LED_DIM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_gen;

  logic i_clock;
  logic i_reset;
  int   checks;
  int   errors;

  led_pattern_gen_if #(.NUM_CH(4)) bus ();

  led_pattern_gen #(
    .NUM_CH     (4),
    .CNT_W      (16),
    .P_HALF_0   (2),
    .P_HALF_1   (3),
    .P_HALF_2   (4),
    .P_HALF_3   (5),
    .BURST_LEN  (2),
    .GAP_HALVES (2)
  ) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic apply_reset(input logic [7:0] mode, input logic [7:0] rate);
    i_reset        = 1'b1;
    bus.i_mode     = mode;
    bus.i_rate_sel = rate;
    bus.i_enable   = 1'b1;
    step();
    step();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_reset        = 1'b1;
    bus.i_enable   = 1'b1;
    bus.i_mode     = 8'hFF;
    bus.i_rate_sel = 8'h00;
    step();
    step();
    checks++;
    if (bus.o_led_drive !== 4'b0000) begin
      errors++;
      $display("FAIL reset_drive: got %b expected 0000", bus.o_led_drive);
    end
    checks++;
    if (bus.o_burst_done !== 4'b0000) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0000", bus.o_burst_done);
    end
  endtask

  task automatic test_blink();
    logic [7:0] pat;
    pat = 8'b11001100;
    apply_reset(8'h02, 8'h00);
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (bus.o_led_drive !== {3'b000, pat[7-k]}) begin
        errors++;
        $display("FAIL blink edge %0d: got %b expected %b", k + 1, bus.o_led_drive,
                 {3'b000, pat[7-k]});
      end
    end
  endtask

  task automatic test_burst();
    logic [17:0] pat;
    logic        e_led;
    logic        e_done;
    pat = 18'b111000111000000000;
    apply_reset(8'h0C, 8'h04);
    for (int k = 1; k <= 36; k++) begin
      step();
      e_led  = pat[17 - ((k - 1) % 18)];
      e_done = (k == 13) || (k == 31);
      checks++;
      if (bus.o_led_drive !== {2'b00, e_led, 1'b0}) begin
        errors++;
        $display("FAIL burst_led edge %0d: got %b expected %b", k, bus.o_led_drive,
                 {2'b00, e_led, 1'b0});
      end
      checks++;
      if (bus.o_burst_done !== {2'b00, e_done, 1'b0}) begin
        errors++;
        $display("FAIL burst_done edge %0d: got %b expected %b", k, bus.o_burst_done,
                 {2'b00, e_done, 1'b0});
      end
    end
  endtask

  task automatic test_rate_change();
    logic [8:0] pat;
    pat = 9'b111100110;
    apply_reset(8'h02, 8'h03);
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if (bus.o_led_drive[0] !== pat[8-k]) begin
        errors++;
        $display("FAIL rate_change edge %0d: got %b expected %b", k + 1,
                 bus.o_led_drive[0], pat[8-k]);
      end
      if (k == 1) bus.i_rate_sel = 8'h00;
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] pat;
    pat = 4'b1110;
    apply_reset(8'h0C, 8'h04);
    for (int k = 0; k < 15; k++) step();
    checks++;
    if (bus.o_led_drive !== 4'b0000) begin
      errors++;
      $display("FAIL mid_gap_led: got %b expected 0000", bus.o_led_drive);
    end
    i_reset = 1'b1;
    step();
    checks++;
    if ((bus.o_led_drive !== 4'b0000) || (bus.o_burst_done !== 4'b0000)) begin
      errors++;
      $display("FAIL mid_gap_reset: got drive %b done %b expected 0000/0000",
               bus.o_led_drive, bus.o_burst_done);
    end
    i_reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (bus.o_led_drive !== {2'b00, pat[3-k], 1'b0}) begin
        errors++;
        $display("FAIL burst_restart edge %0d: got %b expected %b", k + 1,
                 bus.o_led_drive, {2'b00, pat[3-k], 1'b0});
      end
    end
  endtask

  task automatic test_enable();
    logic e;
    apply_reset(8'h02, 8'h00);
    for (int k = 1; k <= 14; k++) begin
      step();
      e = (((k - 1) % 4) < 2);
      if ((k >= 3) && (k <= 9)) e = 1'b0;
      checks++;
      if (bus.o_led_drive !== {3'b000, e}) begin
        errors++;
        $display("FAIL enable edge %0d: got %b expected %b", k, bus.o_led_drive,
                 {3'b000, e});
      end
      if (k == 2) bus.i_enable = 1'b0;
      if (k == 9) bus.i_enable = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    // ch0 ON, ch1 OFF, ch2 mode toggles ON/BLINK, ch3 BLINK with rate toggling
    apply_reset(8'h91, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (bus.o_led_drive !== 4'b1101) begin
        errors++;
        $display("FAIL back_to_back edge %0d: got %b expected 1101", k, bus.o_led_drive);
      end
      bus.i_mode[5:4]     = (bus.i_mode[5:4] == 2'b01) ? 2'b10 : 2'b01;
      bus.i_rate_sel[7:6] = (bus.i_rate_sel[7:6] == 2'b00) ? 2'b01 : 2'b00;
    end
  endtask

`ifdef LED_DIM_EN
  task automatic test_dim();
    logic [3:0] lvl [3];
    int         want [3];
    int         hits;
    lvl[0] = 4'd4;  want[0] = 4;
    lvl[1] = 4'd0;  want[1] = 0;
    lvl[2] = 4'hF;  want[2] = 16;
    for (int t = 0; t < 3; t++) begin
      apply_reset(8'h10, 8'h00);
      bus.i_dim_level = lvl[t];
      step();
      step();
      hits = 0;
      for (int k = 0; k < 16; k++) begin
        step();
        if (bus.o_led_drive[2] === 1'b1) hits++;
      end
      checks++;
      if (hits !== want[t]) begin
        errors++;
        $display("FAIL dim level %0d: got %0d on-cycles expected %0d", lvl[t], hits,
                 want[t]);
      end
    end
    bus.i_dim_level = 4'hF;
  endtask
`endif

  initial begin
    checks         = 0;
    errors         = 0;
    i_reset        = 1'b1;
    bus.i_enable   = 1'b1;
    bus.i_mode     = 8'h00;
    bus.i_rate_sel = 8'h00;
`ifdef LED_DIM_EN
    bus.i_dim_level = 4'hF;
`endif
    test_reset();
    test_blink();
    test_burst();
    test_rate_change();
    test_reset_mid_burst();
    test_enable();
    test_back_to_back();
`ifdef LED_DIM_EN
    test_dim();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
